// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides; one operation in flight.
// Add/sub/shift/logic complete in one cycle, mul and divmod iterate one bit per cycle.
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic [2:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   res,
    output logic                 ov,
    output logic                 dz
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned RW  = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_OR  = 3'b111;

    logic [1:0]       state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [RW-1:0]    res_q, res_d;
    logic             ov_q, ov_d;
    logic             dz_q, dz_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] sub_diff;
    logic [RW-1:0]    alu_res;
    logic             alu_ov, alu_dz, start_iter;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign ov        = ov_q;
    assign dz        = dz_q;

    // Single-cycle result, computed from the operands being latched this edge
    always_comb begin
        add_sum    = {1'b0, op_a} + {1'b0, op_b};
        sub_diff   = op_a - op_b;
        alu_res    = '0;
        alu_ov     = 1'b0;
        alu_dz     = 1'b0;
        start_iter = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res = RW'(add_sum[WIDTH-1:0]);
                alu_ov  = add_sum[WIDTH];
            end
            OP_SUB: begin
                alu_res = RW'(sub_diff);
                alu_ov  = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (op_a[WIDTH-1] != sub_diff[WIDTH-1]);
            end
            OP_MUL: start_iter = 1'b1;
            OP_DIV: begin
                if (op_b == '0) alu_dz = 1'b1;
                else            start_iter = 1'b1;
            end
            OP_SRL: alu_res = RW'(op_a >> op_b[SHW-1:0]);
            OP_SLL: alu_res = RW'(op_a << op_b[SHW-1:0]);
            OP_AND: alu_res = RW'(op_a & op_b);
            OP_OR:  alu_res = RW'(op_a | op_b);
            default: alu_res = '0;
        endcase
    end

    // One iteration: shift-add multiply or restoring divide on {hi,lo}
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_diff = WIDTH'(div_sh - {1'b0, a_q});
        if (op_q == OP_MUL) begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (div_sh >= {1'b0, a_q}) begin
            iter_hi = div_diff;
            iter_lo = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            iter_hi = div_sh[WIDTH-1:0];
            iter_lo = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        ov_d    = ov_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = opcode;
                    if (start_iter) begin
                        // mul: lo holds multiplier, a the multiplicand; div: lo holds dividend, a the divisor
                        state_d = S_BUSY;
                        cnt_d   = '0;
                        hi_d    = '0;
                        a_d     = (opcode == OP_MUL) ? op_a : op_b;
                        lo_d    = (opcode == OP_MUL) ? op_b : op_a;
                    end else begin
                        state_d = S_DONE;
                        res_d   = alu_res;
                        ov_d    = alu_ov;
                        dz_d    = alu_dz;
                    end
                end
            end
            S_BUSY: begin
                hi_d  = iter_hi;
                lo_d  = iter_lo;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    res_d   = {iter_hi, iter_lo};
                    ov_d    = 1'b0;
                    dz_d    = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            res_q       <= '0;
            ov_q        <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            res_q       <= res_d;
            ov_q        <= ov_d;
            dz_q        <= dz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at WIDTH=32 with hand-computed expectations.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] res;
    logic        ov;
    logic        dz;

    int n_tests = 0;
    int n_fail  = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .ov        (ov),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present an operation and return just after the accepting edge
    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [2:0] opc);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        opcode   = opc;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        opcode   = 3'($urandom);
    endtask

    // Count edges from acceptance until out_valid; flag any in_ready seen while busy
    task automatic wait_result(output int lat, output bit rdy_seen);
        lat      = 0;
        rdy_seen = 1'b0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!out_valid && in_ready) rdy_seen = 1'b1;
        end while (!out_valid && lat < 200);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] opc, input logic [63:0] e_res, input logic e_ov,
                          input logic e_dz, input int e_lat);
        int lat;
        bit rdy_seen;
        accept(a, b, opc);
        wait_result(lat, rdy_seen);
        check({tag, "_lat"}, 64'(lat), 64'(e_lat));
        check({tag, "_busy_rdy"}, 64'(rdy_seen), 64'd0);
        check({tag, "_res"}, res, e_res);
        check({tag, "_ov"}, 64'(ov), 64'(e_ov));
        check({tag, "_dz"}, 64'(dz), 64'(e_dz));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_hold"}, res, e_res);
        check({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        opcode    = '0;
        #1;
        check("rst_res", res, 64'd0);
        check("rst_vld", 64'(out_valid), 64'd0);
        check("rst_ov", 64'(ov), 64'd0);
        check("rst_dz", 64'(dz), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rdy", 64'(in_ready), 64'd1);

        run_op("add_carry", 32'hFFFF_FFFF, 32'h1, 3'b000, 64'h0, 1'b1, 1'b0, 1);
        run_op("sub_ovf",   32'h8000_0000, 32'h1, 3'b001, 64'h7FFF_FFFF, 1'b1, 1'b0, 1);
        run_op("sub_small", 32'd5, 32'd3, 3'b001, 64'd2, 1'b0, 1'b0, 1);
        run_op("mul_max",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0, 32);
        run_op("mul_small", 32'h1234_5678, 32'h10, 3'b010, 64'h0000_0001_2345_6780, 1'b0, 1'b0, 32);
        run_op("div_100_7", 32'd100, 32'd7, 3'b011, {32'd2, 32'd14}, 1'b0, 1'b0, 32);
        run_op("div_big",   32'hFFFF_FFFF, 32'h10, 3'b011, {32'hF, 32'h0FFF_FFFF}, 1'b0, 1'b0, 32);
        run_op("div_zero",  32'd9, 32'd0, 3'b011, 64'd0, 1'b0, 1'b1, 1);
        run_op("srl",       32'h8000_0000, 32'h21, 3'b100, 64'h4000_0000, 1'b0, 1'b0, 1);
        run_op("and",       32'hF0F0_F0F0, 32'hFF00_FF00, 3'b110, 64'hF000_F000, 1'b0, 1'b0, 1);
        run_op("or",        32'hF0F0_F0F0, 32'hFF00_FF00, 3'b111, 64'hFFF0_FFF0, 1'b0, 1'b0, 1);

        // Back-pressure: result held while the consumer stalls, new requests ignored
        begin
            int lat;
            bit rdy_seen;
            accept(32'h1, 32'h24, 3'b101);
            wait_result(lat, rdy_seen);
            check("bp_lat", 64'(lat), 64'd1);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                in_valid = 1'b1;
                op_a     = 32'd7;
                op_b     = 32'd9;
                opcode   = 3'b000;
                @(posedge clk);
                #1;
                check("bp_res", res, 64'h10);
                check("bp_vld", 64'(out_valid), 64'd1);
                check("bp_rdy", 64'(in_ready), 64'd0);
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check("bp_consume", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
            check("bp_no_stray", 64'(out_valid), 64'd0);
            check("bp_res_hold", res, 64'h10);
        end

        // Reset in the middle of a multiply discards it
        accept(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_vld", 64'(out_valid), 64'd0);
        check("midrst_res", res, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst_add", 32'd1, 32'd2, 3'b000, 64'd3, 1'b0, 1'b0, 1);
        repeat (40) begin
            @(posedge clk);
            #1;
            check("no_stale_vld", 64'(out_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
